// File: rtl/demux2_stream.sv
// Two-way registered stream demultiplexer: each input beat is steered by in_sel
// into one of two 2-entry FIFOs, each drained by its own valid/ready consumer.
module demux2_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] mem   [2][2];
  logic [1:0]       count [2];
  logic [CNT_W-1:0] cnt   [2];
  logic [1:0]       rdp;
  logic [1:0]       wrp;
  logic [1:0]       push;
  logic [1:0]       pop;

  // Acceptance looks only at the selected FIFO's registered count, so a full
  // FIFO is never refilled through a same-cycle pop.
  assign in_ready = !rst && (in_sel ? (count[1] != 2'd2) : (count[0] != 2'd2));

  always_comb begin
    push    = '0;
    pop     = '0;
    push[0] = in_valid && in_ready && !in_sel;
    push[1] = in_valid && in_ready && in_sel;
    pop[0]  = (count[0] != 2'd0) && out0_ready;
    pop[1]  = (count[1] != 2'd0) && out1_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < 2; e++) begin
          mem[k][e] <= '0;
        end
        count[k] <= '0;
        cnt[k]   <= '0;
      end
      rdp <= '0;
      wrp <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem[k][wrp[k]] <= in_data;
          wrp[k]         <= ~wrp[k];
        end
        if (pop[k]) begin
          rdp[k] <= ~rdp[k];
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 2'd1;
          2'b01:   count[k] <= count[k] - 2'd1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  assign out0_valid = (count[0] != 2'd0);
  assign out1_valid = (count[1] != 2'd0);
  assign out0_data  = mem[0][rdp[0]];
  assign out1_data  = mem[1][rdp[1]];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: stimulus pushes expected beats into
// per-output queues, a negedge monitor compares and pops them.
module tb_demux2_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-output queues of beats not yet consumed, and pop totals.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int  popTotal0 = 0;
  int  popTotal1 = 0;
  bit  willAccept = 1'b0;
  int  rdyMode0 = 1;
  int  rdyMode1 = 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    out0_ready = (rdyMode0 == 2) ? 1'($urandom_range(0, 1)) : (rdyMode0 == 1);
    out1_ready = (rdyMode1 == 2) ? 1'($urandom_range(0, 1)) : (rdyMode1 == 1);
  end

  // Monitor: compare outputs against the model, then apply the coming edge's pops.
  initial begin : monitor
    bit modelReady;
    @(posedge clk);
    forever begin
      @(negedge clk);
      modelReady = !rst && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
      checkOutput("in_ready", 64'(in_ready), 64'(modelReady));
      checkOutput("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
      checkOutput("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
      if (q0.size() != 0) checkOutput("out0_data", 64'(out0_data), 64'(q0[0]));
      else                checkOutput("out0_data_known", 64'($isunknown(out0_data)), 64'(0));
      if (q1.size() != 0) checkOutput("out1_data", 64'(out1_data), 64'(q1[0]));
      else                checkOutput("out1_data_known", 64'($isunknown(out1_data)), 64'(0));
      checkOutput("cnt0", 64'(cnt0), 64'(popTotal0 % CNT_MOD));
      checkOutput("cnt1", 64'(cnt1), 64'(popTotal1 % CNT_MOD));
      willAccept = in_valid && modelReady;
      if (rst) begin
        q0.delete();
        q1.delete();
        popTotal0 = 0;
        popTotal1 = 0;
      end else begin
        if (q0.size() != 0 && out0_ready) begin
          void'(q0.pop_front());
          popTotal0++;
        end
        if (q1.size() != 0 && out1_ready) begin
          void'(q1.pop_front());
          popTotal1++;
        end
      end
    end
  end

  // Presents one beat and holds it until the model says it is taken; called at posedge+1.
  task automatic applyStimulus(input logic sel, input logic [WIDTH-1:0] data, output int stalls);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    stalls   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (willAccept) begin
        @(posedge clk);
        if (sel) q1.push_back(data);
        else     q0.push_back(data);
        #1;
        return;
      end
      stalls++;
    end
    checks++;
    errors++;
    $display("[TB] FAIL accept_timeout: beat %0h sel %0d never accepted", data, sel);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (q0.size() != 0 || q1.size() != 0); c++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(q0.size() + q1.size()), 64'(0));
  endtask

  initial begin : stimulus
    int s;
    int s1;
    int total;
    int base0;
    int base1;

    // Reset held two cycles with a beat offered; nothing may be taken.
    in_valid = 1'b1;
    in_data  = 32'hDEAD0000;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Steering.
    applyStimulus(1'b0, 32'hA0000001, s);
    applyStimulus(1'b1, 32'hB0000002, s);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("steer_cnt0", 64'(cnt0), 64'(1));
    checkOutput("steer_cnt1", 64'(cnt1), 64'(1));

    // Backpressure on output 0: third beat must wait.
    rdyMode0 = 0;
    applyStimulus(1'b0, 32'h1, s);
    applyStimulus(1'b0, 32'h2, s);
    fork
      begin
        repeat (6) @(posedge clk);
        rdyMode0 = 1;
      end
    join_none
    applyStimulus(1'b0, 32'h3, s);
    checkOutput("bp_third_stalled", 64'(s >= 4), 64'(1));
    in_valid = 1'b0;
    drain();
    checkOutput("bp_cnt0", 64'(cnt0), 64'(4));

    // Head-of-line: sel 1 beat waits behind a blocked sel 0 beat.
    rdyMode0 = 0;
    applyStimulus(1'b0, 32'h11, s);
    applyStimulus(1'b0, 32'h12, s);
    fork
      begin
        repeat (5) @(posedge clk);
        rdyMode0 = 1;
      end
    join_none
    applyStimulus(1'b0, 32'h13, s);
    applyStimulus(1'b1, 32'h21, s1);
    checkOutput("hol_sel0_stalled", 64'(s > 0), 64'(1));
    checkOutput("hol_sel1_no_stall", 64'(s1), 64'(0));
    in_valid = 1'b0;
    drain();

    // Streaming 100 alternating beats with both consumers ready; counters wrap.
    base0 = popTotal0;
    base1 = popTotal1;
    total = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'(i % 2), $urandom, s);
      total += s;
    end
    in_valid = 1'b0;
    checkOutput("stream_stalls", 64'(total), 64'(0));
    drain();
    checkOutput("stream_cnt0", 64'(cnt0), 64'((base0 + 50) % CNT_MOD));
    checkOutput("stream_cnt1", 64'(cnt1), 64'((base1 + 50) % CNT_MOD));

    // Reset with both FIFOs full.
    rdyMode0 = 0;
    rdyMode1 = 0;
    applyStimulus(1'b0, 32'hC0, s);
    applyStimulus(1'b1, 32'hD0, s);
    applyStimulus(1'b0, 32'hC1, s);
    applyStimulus(1'b1, 32'hD1, s);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid0", 64'(out0_valid), 64'(0));
    checkOutput("midrst_valid1", 64'(out1_valid), 64'(0));
    checkOutput("midrst_cnt0", 64'(cnt0), 64'(0));
    @(posedge clk);
    #1;
    rdyMode0 = 1;
    rdyMode1 = 1;
    applyStimulus(1'b1, 32'hE0, s);
    applyStimulus(1'b0, 32'hF0, s);
    in_valid = 1'b0;
    drain();

    // Random traffic with random consumer stalls.
    rdyMode0 = 2;
    rdyMode1 = 2;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, s);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rdyMode0 = 1;
    rdyMode1 = 1;
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
